fir_serial_sym: RTL and testbench



---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_mac_unit.sv | 69 ++++++
 rtl/fir_serial_sym.sv | 207 ++++++++++++++++++++
 tb/tb_fir_serial_sym.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the serial-MAC FIR filter (fir_serial_sym and
//   fir_mac_unit): FSM state encoding and the sizing helpers used to derive
//   the accumulator width and the number of stored coefficients.
package fir_pkg;

  // FSM state encoding
  typedef logic [1:0] fir_state_t;
  localparam fir_state_t ST_IDLE = 2'd0;
  localparam fir_state_t ST_MAC  = 2'd1;
  localparam fir_state_t ST_OUT  = 2'd2;

  // Ceiling log2 (returns 0 for values <= 1)
  function automatic int fir_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Full-precision accumulator width: product (with pre-add bit) plus
  // growth for summing up to N_TAPS terms.
  function automatic int fir_acc_w(input int x_w, input int c_w, input int n_taps);
    return x_w + c_w + 1 + fir_clog2(n_taps);
  endfunction

  // Number of stored coefficients (folded mode keeps only half the taps)
  function automatic int fir_nc(input int n_taps, input int sym);
    return (sym != 0) ? (n_taps + 1) / 2 : n_taps;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit
//   One multiply-accumulate term per enabled cycle:
//     sum = acc + coef * (bypass ? da : da + db)
//   The pre-add is X_W+1 bits wide so the symmetric pair sum never overflows.
//   The accumulator is cleared by i_clr and loaded with the running sum on
//   i_en. o_sum is the combinational sum including the current term, so the
//   caller can capture the final result on the same edge as the last term.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   i_clr     in   clear accumulator (priority over i_en)
//   i_en      in   add the current term into the accumulator
//   i_bypass  in   1 = use i_da alone, 0 = use i_da + i_db
//   i_coef    in   C_W signed coefficient
//   i_da      in   X_W signed sample (primary)
//   i_db      in   X_W signed sample (mirrored partner)
//   o_sum     out  ACC_W signed accumulator + current term
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int C_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bypass,
  input  logic [C_W-1:0]   i_coef,
  input  logic [X_W-1:0]   i_da,
  input  logic [X_W-1:0]   i_db,
  output logic [ACC_W-1:0] o_sum
);

  localparam int PROD_W = X_W + 1 + C_W;

  logic signed [X_W:0]       w_pre;
  logic signed [PROD_W-1:0]  w_pre_x;
  logic signed [PROD_W-1:0]  w_coef_x;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   r_acc;

  always_comb begin
    if (i_bypass) w_pre = (X_W+1)'($signed(i_da));
    else          w_pre = (X_W+1)'($signed(i_da)) + (X_W+1)'($signed(i_db));
  end

  // Both operands widened to the full product width so the multiply is
  // exact in the assignment width.
  assign w_pre_x  = PROD_W'(w_pre);
  assign w_coef_x = PROD_W'($signed(i_coef));
  assign w_prod   = w_pre_x * w_coef_x;
  assign w_sum    = r_acc + ACC_W'(w_prod);
  assign o_sum    = w_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/fir_serial_sym.sv
// fir_serial_sym
//   Parametrised serial-MAC FIR filter with optional symmetric folding.
//   One output per accepted input; each output takes M = NC MAC cycles
//   (NC = ceil(N_TAPS/2) when SYM=1, else N_TAPS). Coefficients are loaded
//   through a shift register (the last value loaded becomes h[0]); reset
//   leaves an identity filter (h[0]=1).
//
//   Build option: define FIR_SAT_EN to saturate the shifted accumulator to
//   the signed Y_W range and expose sat_flag; otherwise the output wraps
//   (LSBs kept) and there is no sat_flag port.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   s_tdata     in   X_W signed input sample
//   s_tvalid    in   input sample valid
//   s_tready    out  sample accepted (IDLE and no coefficient pending)
//   coef_data   in   C_W signed coefficient
//   coef_valid  in   coefficient valid
//   coef_ready  out  coefficient accepted (IDLE)
//   m_tdata     out  Y_W signed filtered output
//   m_tvalid    out  output valid
//   m_tready    in   downstream accepts output
//   sat_flag    out  (FIR_SAT_EN only) output was clipped
module fir_serial_sym
  import fir_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int C_W       = 8,
  parameter int N_TAPS    = 8,
  parameter int SYM       = 1,
  parameter int OUT_SHIFT = 0,
  parameter int Y_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] s_tdata,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [C_W-1:0] coef_data,
  input  logic           coef_valid,
  output logic           coef_ready,
  output logic [Y_W-1:0] m_tdata,
  output logic           m_tvalid,
  input  logic           m_tready
`ifdef FIR_SAT_EN
  ,
  output logic           sat_flag
`endif
);

  localparam int ACC_W   = fir_acc_w(X_W, C_W, N_TAPS);
  localparam int NC      = fir_nc(N_TAPS, SYM);
  localparam int M       = NC;
  localparam int IDX_W   = fir_clog2(N_TAPS);
  localparam bit ODD_MID = (SYM != 0) && ((N_TAPS % 2) == 1);

  fir_state_t              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [X_W-1:0]          r_dly [N_TAPS];
  logic [C_W-1:0]          r_coef [NC];
  logic [Y_W-1:0]          r_m_tdata;
  logic                    r_m_tvalid;

  logic                    w_idle;
  logic                    w_coef_hs;
  logic                    w_samp_hs;
  logic                    w_last;
  logic                    w_bypass;
  logic [C_W-1:0]          w_coef;
  logic [X_W-1:0]          w_da;
  logic [X_W-1:0]          w_db;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;
  logic [Y_W-1:0]          w_y;

  // Handshakes: a pending coefficient blocks the sample in the same cycle
  assign w_idle     = (r_state == ST_IDLE);
  assign coef_ready = w_idle;
  assign s_tready   = w_idle && !coef_valid;
  assign w_coef_hs  = w_idle && coef_valid;
  assign w_samp_hs  = s_tvalid && s_tready;
  assign w_last     = (r_idx == IDX_W'(M - 1));

  // Generic mode never pre-adds; folded odd-length uses the centre tap once
  assign w_bypass   = (SYM == 0) || (ODD_MID && w_last);

  // Operand selection: h[idx], d[idx] and its mirror d[N_TAPS-1-idx]
  always_comb begin
    w_coef = '0;
    w_da   = '0;
    w_db   = '0;
    for (int k = 0; k < NC; k++) begin
      if (r_idx == IDX_W'(k)) w_coef = r_coef[k];
    end
    for (int k = 0; k < N_TAPS; k++) begin
      if (r_idx == IDX_W'(k))              w_da = r_dly[k];
      if (r_idx == IDX_W'(N_TAPS - 1 - k)) w_db = r_dly[k];
    end
  end

  fir_mac_unit #(
    .X_W   (X_W),
    .C_W   (C_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_samp_hs),
    .i_en     (r_state == ST_MAC),
    .i_bypass (w_bypass),
    .i_coef   (w_coef),
    .i_da     (w_da),
    .i_db     (w_db),
    .o_sum    (w_sum)
  );

  // Output scaling and width reduction
  assign w_shift = w_sum >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
  logic w_ovf;
  logic r_sat;

  generate
    if (Y_W < ACC_W) begin : g_sat_chk
      // In range only when all bits from the Y_W sign position upward agree
      assign w_ovf = !((&w_shift[ACC_W-1:Y_W-1]) || !(|w_shift[ACC_W-1:Y_W-1]));
    end else begin : g_sat_none
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign w_y = w_ovf ? {w_shift[ACC_W-1], {(Y_W-1){~w_shift[ACC_W-1]}}}
                     : Y_W'(w_shift);
  assign sat_flag = r_sat;
`else
  assign w_y = Y_W'(w_shift);
`endif

  // Coefficient shift register: newest value lands in h[0]
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NC; k++) r_coef[k] <= '0;
      r_coef[0] <= C_W'(1);
    end else if (w_coef_hs) begin
      r_coef[0] <= coef_data;
      for (int k = 1; k < NC; k++) r_coef[k] <= r_coef[k-1];
    end
  end

  // Sample delay line: d[0] newest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_TAPS; k++) r_dly[k] <= '0;
    end else if (w_samp_hs) begin
      r_dly[0] <= s_tdata;
      for (int k = 1; k < N_TAPS; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // Control FSM and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
`ifdef FIR_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_samp_hs) begin
            r_idx   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_last) begin
            // Capture the sum that includes the final term
            r_m_tdata  <= w_y;
            r_m_tvalid <= 1'b1;
`ifdef FIR_SAT_EN
            r_sat      <= w_ovf;
`endif
            r_state    <= ST_OUT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_tready) begin
            r_m_tvalid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_fir_serial_sym.sv
// tb_fir_serial_sym
//   Directed + randomized checks of fir_serial_sym against a direct-form
//   convolution reference. Two instances:
//     u_sym : N_TAPS=5, SYM=1, OUT_SHIFT=0, Y_W=8   (M = 3)
//     u_gen : N_TAPS=4, SYM=0, OUT_SHIFT=3, Y_W=12  (M = 4)
module tb_fir_serial_sym;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // u_sym signals
  logic [7:0]  a_s_tdata, a_coef_data, a_m_tdata;
  logic        a_s_tvalid, a_s_tready, a_coef_valid, a_coef_ready;
  logic        a_m_tvalid, a_m_tready, a_sat;
  // u_gen signals
  logic [7:0]  b_s_tdata, b_coef_data;
  logic [11:0] b_m_tdata;
  logic        b_s_tvalid, b_s_tready, b_coef_valid, b_coef_ready;
  logic        b_m_tvalid, b_m_tready, b_sat;

  // Reference state: loaded coefficients (index 0 = last loaded) and history
  int a_c[8], a_d[8], b_c[8], b_d[8];

  fir_serial_sym #(.X_W(8), .C_W(8), .N_TAPS(5), .SYM(1), .OUT_SHIFT(0), .Y_W(8)) u_sym (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (a_s_tdata),
    .s_tvalid   (a_s_tvalid),
    .s_tready   (a_s_tready),
    .coef_data  (a_coef_data),
    .coef_valid (a_coef_valid),
    .coef_ready (a_coef_ready),
    .m_tdata    (a_m_tdata),
    .m_tvalid   (a_m_tvalid),
    .m_tready   (a_m_tready)
`ifdef FIR_SAT_EN
    ,
    .sat_flag   (a_sat)
`endif
  );

  fir_serial_sym #(.X_W(8), .C_W(8), .N_TAPS(4), .SYM(0), .OUT_SHIFT(3), .Y_W(12)) u_gen (
    .clk        (clk),
    .reset      (reset),
    .s_tdata    (b_s_tdata),
    .s_tvalid   (b_s_tvalid),
    .s_tready   (b_s_tready),
    .coef_data  (b_coef_data),
    .coef_valid (b_coef_valid),
    .coef_ready (b_coef_ready),
    .m_tdata    (b_m_tdata),
    .m_tvalid   (b_m_tvalid),
    .m_tready   (b_m_tready)
`ifdef FIR_SAT_EN
    ,
    .sat_flag   (b_sat)
`endif
  );

`ifndef FIR_SAT_EN
  assign a_sat = 1'b0;
  assign b_sat = 1'b0;
`endif

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direct-form reference: y = sum_k h[k]*d[k], h mirrored in folded mode,
  // then shift and reduce to yw bits (saturate or wrap).
  function automatic longint fir_ref(input int n, input int sym, input int sh,
                                     input int yw, input int c[8], input int d[8],
                                     output bit clip);
    longint acc, s, m, t;
    int     nc, h;
    nc  = (sym != 0) ? (n + 1) / 2 : n;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      h   = (k < nc) ? c[k] : c[n-1-k];
      acc += longint'(h) * longint'(d[k]);
    end
    s    = acc >>> sh;
    m    = longint'(1) <<< yw;
    clip = (s > m/2 - 1) || (s < -(m/2));
`ifdef FIR_SAT_EN
    if (s > m/2 - 1)       t = m/2 - 1;
    else if (s < -(m/2))   t = -(m/2);
    else                   t = s;
`else
    t = s & (m - 1);
    if (t >= m/2) t -= m;
`endif
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      a_c[k] = 0; a_d[k] = 0; b_c[k] = 0; b_d[k] = 0;
    end
    a_c[0] = 1;
    b_c[0] = 1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- u_sym helpers ----------------
  task automatic a_load(input int v);
    a_coef_data  = 8'(v);
    a_coef_valid = 1'b1;
    #1;
    check("a_coef_ready", a_coef_ready, 1);
    @(negedge clk);
    a_coef_valid = 1'b0;
    for (int k = 7; k > 0; k--) a_c[k] = a_c[k-1];
    a_c[0] = v;
    $display("a coef load %0d", v);
  endtask

  task automatic a_accept(input int x, output int waited);
    a_s_tdata  = 8'(x);
    a_s_tvalid = 1'b1;
    #1;
    waited = 0;
    while (a_s_tready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check("a_s_tready", a_s_tready, 1);
    @(negedge clk);
    a_s_tvalid = 1'b0;
    for (int k = 7; k > 0; k--) a_d[k] = a_d[k-1];
    a_d[0] = x;
  endtask

  task automatic a_collect(input bit rel, output longint got, output longint exp);
    int cyc;
    bit clip;
    cyc = 0;
    while (a_m_tvalid !== 1'b1 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    check("a_latency", cyc, 3);
    exp = fir_ref(5, 1, 0, 8, a_c, a_d, clip);
    got = longint'($signed(a_m_tdata));
    check("a_data", $signed(a_m_tdata), exp);
`ifdef FIR_SAT_EN
    check("a_sat_flag", a_sat, clip);
`endif
    $display("a sample %0d -> out %0d (ref %0d) latency %0d", a_d[0], got, exp, cyc);
    if (rel) begin
      a_m_tready = 1'b1;
      @(negedge clk);
      a_m_tready = 1'b0;
      #1;
      check("a_tvalid_drop", a_m_tvalid, 0);
    end
  endtask

  // ---------------- u_gen helpers ----------------
  task automatic b_load(input int v);
    b_coef_data  = 8'(v);
    b_coef_valid = 1'b1;
    #1;
    check("b_coef_ready", b_coef_ready, 1);
    @(negedge clk);
    b_coef_valid = 1'b0;
    for (int k = 7; k > 0; k--) b_c[k] = b_c[k-1];
    b_c[0] = v;
    $display("b coef load %0d", v);
  endtask

  task automatic b_accept(input int x);
    int waited;
    b_s_tdata  = 8'(x);
    b_s_tvalid = 1'b1;
    #1;
    waited = 0;
    while (b_s_tready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check("b_s_tready", b_s_tready, 1);
    @(negedge clk);
    b_s_tvalid = 1'b0;
    for (int k = 7; k > 0; k--) b_d[k] = b_d[k-1];
    b_d[0] = x;
  endtask

  task automatic b_collect(input int hold);
    int cyc;
    bit clip;
    longint exp;
    cyc = 0;
    while (b_m_tvalid !== 1'b1 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    check("b_latency", cyc, 4);
    exp = fir_ref(4, 0, 3, 12, b_c, b_d, clip);
    check("b_data", $signed(b_m_tdata), exp);
`ifdef FIR_SAT_EN
    check("b_sat_flag", b_sat, clip);
`endif
    $display("b sample %0d -> out %0d (ref %0d) hold %0d", b_d[0],
             longint'($signed(b_m_tdata)), exp, hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_data", $signed(b_m_tdata), exp);
    end
    b_m_tready = 1'b1;
    @(negedge clk);
    b_m_tready = 1'b0;
    #1;
    check("b_tvalid_drop", b_m_tvalid, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int     waited;
    longint got, exp;
    int     id_in[3];
    int     imp_in[6];
    int     imp_exp[6];
    id_in   = '{5, -3, 127};
    imp_in  = '{1, 0, 0, 0, 0, 0};
    imp_exp = '{1, 2, 3, 2, 1, 0};

    reset = 1'b0;
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_coef_data = '0; a_coef_valid = 1'b0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_coef_data = '0; b_coef_valid = 1'b0; b_m_tready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;

    // Reset state
    check("rst_a_tvalid", a_m_tvalid, 0);
    check("rst_a_tdata",  a_m_tdata, 0);
    check("rst_a_s_tready", a_s_tready, 1);
    check("rst_a_coef_ready", a_coef_ready, 1);
    check("rst_b_tvalid", b_m_tvalid, 0);
    check("rst_b_tdata",  b_m_tdata, 0);
    check("rst_b_s_tready", b_s_tready, 1);
    check("rst_b_coef_ready", b_coef_ready, 1);
    $display("reset state checked");

    // Identity filter after reset
    for (int i = 0; i < 3; i++) begin
      a_accept(id_in[i], waited);
      a_collect(1'b1, got, exp);
      check("identity_out", got, id_in[i]);
    end

    // Coefficient has priority over a simultaneous sample
    @(negedge clk);
    a_coef_data  = 8'(4);
    a_coef_valid = 1'b1;
    a_s_tdata    = 8'(-7);
    a_s_tvalid   = 1'b1;
    #1;
    check("prio_s_tready_low", a_s_tready, 0);
    check("prio_coef_ready", a_coef_ready, 1);
    @(negedge clk);
    a_coef_valid = 1'b0;
    for (int k = 7; k > 0; k--) a_c[k] = a_c[k-1];
    a_c[0] = 4;
    a_accept(-7, waited);
    check("prio_sample_next_cycle", waited, 0);
    a_collect(1'b1, got, exp);
    $display("priority step done");

    // Backpressure: hold output 10 cycles with a sample waiting
    a_accept(33, waited);
    a_collect(1'b0, got, exp);
    a_s_tdata  = 8'(-20);
    a_s_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", $signed(a_m_tdata), exp);
      check("bp_hold_valid", a_m_tvalid, 1);
      check("bp_s_tready_low", a_s_tready, 0);
    end
    a_m_tready = 1'b1;
    @(negedge clk);
    a_m_tready = 1'b0;
    #1;
    check("bp_out_exit", a_m_tvalid, 0);
    check("bp_accept_next", a_s_tready, 1);
    @(negedge clk);
    a_s_tvalid = 1'b0;
    for (int k = 7; k > 0; k--) a_d[k] = a_d[k-1];
    a_d[0] = -20;
    a_collect(1'b1, got, exp);
    $display("backpressure step done");

    // Async reset while output is held
    a_accept(20, waited);
    a_collect(1'b0, got, exp);
    #2;
    reset = 1'b0;
    #1;
    check("areset_out_tvalid", a_m_tvalid, 0);
    check("areset_out_tdata", a_m_tdata, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Async reset mid-MAC, then identity on the next sample
    a_load(6);
    a_accept(9, waited);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("areset_mac_tvalid", a_m_tvalid, 0);
    check("areset_mac_s_tready", a_s_tready, 1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    a_accept(42, waited);
    a_collect(1'b1, got, exp);
    check("areset_identity", got, 42);
    $display("async reset steps done");

    // Symmetric coefficient load and impulse response
    do_reset();
    a_load(3);
    a_load(2);
    a_load(1);
    for (int i = 0; i < 6; i++) begin
      a_accept(imp_in[i], waited);
      a_collect(1'b1, got, exp);
      check("impulse_out", got, imp_exp[i]);
    end

    // Full-scale taps and inputs: saturate or wrap
    a_load(127);
    a_load(127);
    a_load(127);
    for (int i = 0; i < 5; i++) begin
      a_accept(127, waited);
      a_collect(1'b0, got, exp);
      if (i < 4) begin
        a_m_tready = 1'b1;
        @(negedge clk);
        a_m_tready = 1'b0;
      end
    end
`ifdef FIR_SAT_EN
    check("fullscale_sat_value", got, 127);
    check("fullscale_sat_flag", a_sat, 1);
`else
    check("fullscale_wrap_value", got, 5);
`endif
    a_m_tready = 1'b1;
    @(negedge clk);
    a_m_tready = 1'b0;

    // Randomized folded-mode traffic
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) a_load(int'($urandom_range(0, 255)) - 128);
      a_accept(int'($urandom_range(0, 255)) - 128, waited);
      a_collect(1'b1, got, exp);
    end

    // Randomized generic-mode traffic on u_gen
    for (int i = 0; i < 4; i++) b_load(int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 4) == 0) b_load(int'($urandom_range(0, 255)) - 128);
      b_accept(int'($urandom_range(0, 255)) - 128);
      b_collect(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
